// File: rtl/ctrl_param_pkg.sv
// Shared definitions for the double-buffered parameter bank: command encoding,
// field widths, entry/global layouts and power-on defaults.
package ctrl_param_pkg;

  localparam logic [31:0] MAGIC_DEFAULT = 32'hF0AA550F;

  localparam logic [3:0] NCMD_MASK      = 4'd1;
  localparam logic [3:0] NCMD_RXIDX     = 4'd2;
  localparam logic [3:0] NCMD_HIT       = 4'd3;
  localparam logic [3:0] NCMD_GND       = 4'd4;
  localparam logic [3:0] NCMD_HUSH      = 4'd5;
  localparam logic [3:0] NCMD_COUNT     = 4'd6;
  localparam logic [3:0] NCMD_DAC       = 4'd7;
  localparam logic [3:0] NCMD_RATIO     = 4'd8;
  localparam logic [3:0] NCMD_TICK      = 4'd9;
  localparam logic [3:0] NCMD_SLOT_TIME = 4'd10;
  localparam logic [3:0] NCMD_DELAY     = 4'd11;
  localparam logic [3:0] NCMD_SYNC      = 4'd12;
  localparam logic [3:0] NCMD_FRAME     = 4'd13;

  localparam int CMD_RSV_BIT  = 31;
  localparam int CMD_RD_BIT   = 30;
  localparam int CMD_NCMD_LSB = 26;
  localparam int CMD_CH_LSB   = 22;
  localparam int CMD_SLOT_LSB = 18;

  localparam int MASK_W  = 4;
  localparam int VCHN_W  = 2;
  localparam int HIT_W   = 8;
  localparam int GND_W   = 8;
  localparam int HUSH_W  = 16;
  localparam int COUNT_W = 4;
  localparam int DAC_W   = 8;
  localparam int RATIO_W = 8;
  localparam int TICK_W  = 8;
  localparam int DELAY_W = 8;
  localparam int TS_W    = 16;

  localparam logic [TS_W-1:0]    TS_TIME_DEF    = 16'd3600;
  localparam logic [HIT_W-1:0]   HIT_DEF        = 8'd20;
  localparam logic [HIT_W-1:0]   HIT_LAST_DEF   = 8'd10;
  localparam logic [GND_W-1:0]   GND_DEF        = 8'd20;
  localparam logic [GND_W-1:0]   GND_LAST_DEF   = 8'd30;
  localparam logic [COUNT_W-1:0] COUNT_DEF      = 4'd4;
  localparam logic [COUNT_W-1:0] COUNT_LAST_DEF = 4'd1;
  localparam logic [HUSH_W-1:0]  HUSH_DEF       = 16'd1000;
  localparam logic [TICK_W-1:0]  TICK_DEF       = 8'd64;
  localparam logic [RATIO_W-1:0] RATIO_DEF      = 8'd12;
  localparam logic [DAC_W-1:0]   DAC_DEF        = 8'd120;
  localparam logic [DELAY_W-1:0] DELAY_DEF      = 8'd0;

  typedef struct packed {
    logic [MASK_W-1:0]  mask;
    logic [VCHN_W-1:0]  vchn;
    logic [HIT_W-1:0]   hit;
    logic [GND_W-1:0]   gnd;
    logic [HUSH_W-1:0]  hush;
    logic [COUNT_W-1:0] count;
    logic [DAC_W-1:0]   dac;
    logic [RATIO_W-1:0] ratio;
    logic [TICK_W-1:0]  tick;
    logic [DELAY_W-1:0] delay;
  } entry_t;

  typedef struct packed {
    logic [15:0] sync_div;
    logic        sync_en;
    logic        int_ext;
    logic [7:0]  wheel_add;
    logic [7:0]  frame_dec;
  } glob_t;

  localparam glob_t GLOB_DEF = '{sync_div: 16'd100, sync_en: 1'b1, int_ext: 1'b1,
                                 wheel_add: 8'd9, frame_dec: 8'd234};

  typedef enum logic {ST_IDLE, ST_RESP} rd_state_t;

  // The last entry of the whole bank carries distinct hit/gnd/count defaults.
  function automatic entry_t entry_default(input int unsigned idx, input int unsigned n_ch,
                                           input int unsigned n_slot);
    entry_t      e;
    int unsigned ch;
    logic        last;
    ch      = idx / n_slot;
    last    = (idx == n_ch * n_slot - 1);
    e.mask  = MASK_W'(1 << (ch % 4));
    e.vchn  = VCHN_W'(ch % 4);
    e.hit   = last ? HIT_LAST_DEF : HIT_DEF;
    e.gnd   = last ? GND_LAST_DEF : GND_DEF;
    e.hush  = HUSH_DEF;
    e.count = last ? COUNT_LAST_DEF : COUNT_DEF;
    e.dac   = DAC_DEF;
    e.ratio = RATIO_DEF;
    e.tick  = TICK_DEF;
    e.delay = DELAY_DEF;
    return e;
  endfunction

endpackage

// File: rtl/ctrl_param_dec.sv
// Combinational host command decode: field extraction, validation and the
// write/read/error strobes for an accepted command.
module ctrl_param_dec
  import ctrl_param_pkg::*;
#(
  parameter int          N_CH   = 4,
  parameter int          N_SLOT = 4,
  parameter logic [31:0] MAGIC  = MAGIC_DEFAULT,
  parameter int          IDX_W  = (N_CH * N_SLOT > 1) ? $clog2(N_CH * N_SLOT) : 1,
  parameter int          SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1
) (
  input  logic [31:0]       i_magic,
  input  logic [31:0]       i_command,
  input  logic              i_vld,
  input  logic              i_rdy,
  output logic              o_wr_en,
  output logic              o_rd_en,
  output logic              o_err,
  output logic [3:0]        o_ncmd,
  output logic [IDX_W-1:0]  o_idx,
  output logic [SLOT_W-1:0] o_slot,
  output logic [15:0]       o_data
);

  logic [3:0] ch;
  logic [3:0] slot;
  logic       uses_ch;
  logic       uses_slot;
  logic       bad;
  logic       acc;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^i_command[17:16];

  // NOTE: every output is assigned before any branch, so no latch is inferred.
  always_comb begin
    o_ncmd    = i_command[CMD_NCMD_LSB +: 4];
    ch        = i_command[CMD_CH_LSB +: 4];
    slot      = i_command[CMD_SLOT_LSB +: 4];
    o_data    = i_command[15:0];
    uses_ch   = o_ncmd inside {[NCMD_MASK:NCMD_TICK], NCMD_DELAY};
    uses_slot = uses_ch || (o_ncmd == NCMD_SLOT_TIME);
    bad       = (i_magic != MAGIC) || i_command[CMD_RSV_BIT] ||
                (o_ncmd < NCMD_MASK) || (o_ncmd > NCMD_FRAME) ||
                (uses_ch && (32'(ch) >= N_CH)) ||
                (uses_slot && (32'(slot) >= N_SLOT));
    acc       = i_vld && i_rdy;
    o_wr_en   = acc && !bad && !i_command[CMD_RD_BIT];
    o_rd_en   = acc && !bad && i_command[CMD_RD_BIT];
    o_err     = acc && bad;
    o_idx     = IDX_W'(32'(ch) * N_SLOT + 32'(slot));
    o_slot    = slot[SLOT_W-1:0];
  end

endmodule

// File: rtl/ctrl_param_bank.sv
// Double-buffered parameter store: host writes land in shadow, a frame commit
// copies shadow to active, and active drives the slot-indexed parameter buses.
module ctrl_param_bank
  import ctrl_param_pkg::*;
#(
  parameter int          N_CH   = 4,
  parameter int          N_SLOT = 4,
  parameter logic [31:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            i_cmd_magic,
  input  logic [31:0]            i_cmd_command,
  input  logic                   i_cmd_vld,
  output logic                   o_cmd_rdy,
  output logic [15:0]            o_rd_data,
  output logic                   o_rd_vld,
  input  logic                   i_rd_rdy,
  input  logic                   i_commit,
  output logic                   o_commit_done,
  output logic                   o_dirty,
  output logic [7:0]             o_err_cnt,
  input  logic [3:0]             i_slot,
  output logic [TS_W*N_SLOT-1:0] o_ts_time,
  output logic [MASK_W*N_CH-1:0] o_pulse_mask,
  output logic [8*N_CH-1:0]      o_pulse_hit,
  output logic [8*N_CH-1:0]      o_pulse_gnd,
  output logic [4*N_CH-1:0]      o_pulse_count,
  output logic [16*N_CH-1:0]     o_pulse_hush,
  output logic [2*N_CH-1:0]      o_adc_vchn,
  output logic [8*N_CH-1:0]      o_adc_tick,
  output logic [8*N_CH-1:0]      o_adc_ratio,
  output logic [8*N_CH-1:0]      o_dac_level,
  output logic [8*N_CH-1:0]      o_adc_delay,
  output logic [15:0]            o_in_sync_div,
  output logic                   o_sync_enabled,
  output logic                   o_int_ext_sync,
  output logic [7:0]             o_wheel_add,
  output logic [7:0]             o_frame_dec
);

  localparam int N_ENT  = N_CH * N_SLOT;
  localparam int IDX_W  = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  logic              dec_wr_en, dec_rd_en, dec_err;
  logic [3:0]        dec_ncmd;
  logic [IDX_W-1:0]  dec_idx;
  logic [SLOT_W-1:0] dec_slot;
  logic [15:0]       dec_data;

  entry_t      shadow_q [N_ENT];
  entry_t      shadow_d [N_ENT];
  entry_t      active_q [N_ENT];
  entry_t      active_d [N_ENT];
  logic [15:0] ts_shadow_q [N_SLOT];
  logic [15:0] ts_shadow_d [N_SLOT];
  logic [15:0] ts_active_q [N_SLOT];
  logic [15:0] ts_active_d [N_SLOT];
  glob_t       glob_shadow_q, glob_shadow_d, glob_active_q, glob_active_d;

  rd_state_t   state_q, state_d;
  logic [15:0] rd_data_q, rd_data_d, rd_word;
  logic        dirty_q, dirty_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        commit_done_q, commit_done_d;
  logic        commit_fire;

  entry_t      ch_out_q [N_CH];
  entry_t      ch_out_d [N_CH];
  logic [15:0] ts_out_q [N_SLOT];
  logic [15:0] ts_out_d [N_SLOT];
  glob_t       glob_out_q, glob_out_d;
  logic [SLOT_W-1:0] slot_sel;
  entry_t      rd_ent;
  logic        unused_slot_bits;

  assign unused_slot_bits = ^i_slot;
  assign o_cmd_rdy        = (state_q == ST_IDLE);
  assign commit_fire      = i_commit && dirty_q;

  ctrl_param_dec #(.N_CH(N_CH), .N_SLOT(N_SLOT), .MAGIC(MAGIC), .IDX_W(IDX_W), .SLOT_W(SLOT_W))
  u_dec (
    .i_magic(i_cmd_magic), .i_command(i_cmd_command), .i_vld(i_cmd_vld), .i_rdy(o_cmd_rdy),
    .o_wr_en(dec_wr_en), .o_rd_en(dec_rd_en), .o_err(dec_err), .o_ncmd(dec_ncmd),
    .o_idx(dec_idx), .o_slot(dec_slot), .o_data(dec_data)
  );

  // Commit copies the pre-write shadow; a same-cycle write only touches shadow.
  always_comb begin
    shadow_d      = shadow_q;
    ts_shadow_d   = ts_shadow_q;
    glob_shadow_d = glob_shadow_q;
    active_d      = active_q;
    ts_active_d   = ts_active_q;
    glob_active_d = glob_active_q;
    if (commit_fire) begin
      active_d      = shadow_q;
      ts_active_d   = ts_shadow_q;
      glob_active_d = glob_shadow_q;
    end
    if (dec_wr_en) begin
      case (dec_ncmd)
        NCMD_MASK:      shadow_d[dec_idx].mask  = dec_data[MASK_W-1:0];
        NCMD_RXIDX:     shadow_d[dec_idx].vchn  = dec_data[VCHN_W-1:0];
        NCMD_HIT:       shadow_d[dec_idx].hit   = dec_data[HIT_W-1:0];
        NCMD_GND:       shadow_d[dec_idx].gnd   = dec_data[GND_W-1:0];
        NCMD_HUSH:      shadow_d[dec_idx].hush  = dec_data;
        NCMD_COUNT:     shadow_d[dec_idx].count = dec_data[COUNT_W-1:0];
        NCMD_DAC:       shadow_d[dec_idx].dac   = dec_data[DAC_W-1:0];
        NCMD_RATIO:     shadow_d[dec_idx].ratio = dec_data[RATIO_W-1:0];
        NCMD_TICK:      shadow_d[dec_idx].tick  = dec_data[TICK_W-1:0];
        NCMD_DELAY:     shadow_d[dec_idx].delay = dec_data[DELAY_W-1:0];
        NCMD_SLOT_TIME: ts_shadow_d[dec_slot]   = dec_data;
        NCMD_SYNC: begin
          glob_shadow_d.sync_en  = dec_data[15];
          glob_shadow_d.int_ext  = dec_data[14];
          glob_shadow_d.sync_div = {3'b000, dec_data[12:0]};
        end
        NCMD_FRAME: begin
          glob_shadow_d.wheel_add = dec_data[15:8];
          glob_shadow_d.frame_dec = dec_data[7:0];
        end
        default: ;
      endcase
    end
  end

  // Readback uses the same packing as the write path.
  always_comb begin
    rd_ent = shadow_q[dec_idx];
    case (dec_ncmd)
      NCMD_MASK:      rd_word = 16'(rd_ent.mask);
      NCMD_RXIDX:     rd_word = 16'(rd_ent.vchn);
      NCMD_HIT:       rd_word = 16'(rd_ent.hit);
      NCMD_GND:       rd_word = 16'(rd_ent.gnd);
      NCMD_HUSH:      rd_word = rd_ent.hush;
      NCMD_COUNT:     rd_word = 16'(rd_ent.count);
      NCMD_DAC:       rd_word = 16'(rd_ent.dac);
      NCMD_RATIO:     rd_word = 16'(rd_ent.ratio);
      NCMD_TICK:      rd_word = 16'(rd_ent.tick);
      NCMD_DELAY:     rd_word = 16'(rd_ent.delay);
      NCMD_SLOT_TIME: rd_word = ts_shadow_q[dec_slot];
      NCMD_SYNC:      rd_word = {glob_shadow_q.sync_en, glob_shadow_q.int_ext, 1'b0,
                                 glob_shadow_q.sync_div[12:0]};
      NCMD_FRAME:     rd_word = {glob_shadow_q.wheel_add, glob_shadow_q.frame_dec};
      default:        rd_word = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rd_data_d     = rd_data_q;
    dirty_d       = dirty_q;
    err_cnt_d     = err_cnt_q;
    commit_done_d = commit_fire;
    case (state_q)
      ST_IDLE: if (dec_rd_en) begin
        state_d   = ST_RESP;
        rd_data_d = rd_word;
      end
      ST_RESP: if (i_rd_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (dec_wr_en)        dirty_d = 1'b1;
    else if (commit_fire) dirty_d = 1'b0;
    if (dec_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Slot indices beyond N_SLOT (non-power-of-two banks) fall back to slot 0.
  always_comb begin
    slot_sel   = (32'(i_slot[SLOT_W-1:0]) < N_SLOT) ? i_slot[SLOT_W-1:0] : '0;
    ts_out_d   = ts_active_q;
    glob_out_d = glob_active_q;
    for (int c = 0; c < N_CH; c++) begin
      ch_out_d[c] = active_q[IDX_W'(c * N_SLOT + 32'(slot_sel))];
    end
  end

  // NOTE: the banks are flop arrays, not RAM, so both are reset to their
  // defaults; outputs come up holding the slot-0 defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        shadow_q[i] <= entry_default(i, N_CH, N_SLOT);
        active_q[i] <= entry_default(i, N_CH, N_SLOT);
      end
      for (int s = 0; s < N_SLOT; s++) begin
        ts_shadow_q[s] <= TS_TIME_DEF;
        ts_active_q[s] <= TS_TIME_DEF;
        ts_out_q[s]    <= TS_TIME_DEF;
      end
      for (int c = 0; c < N_CH; c++) ch_out_q[c] <= entry_default(c * N_SLOT, N_CH, N_SLOT);
      glob_shadow_q <= GLOB_DEF;
      glob_active_q <= GLOB_DEF;
      glob_out_q    <= GLOB_DEF;
      state_q       <= ST_IDLE;
      rd_data_q     <= '0;
      dirty_q       <= 1'b0;
      err_cnt_q     <= '0;
      commit_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      ts_shadow_q   <= ts_shadow_d;
      ts_active_q   <= ts_active_d;
      ts_out_q      <= ts_out_d;
      ch_out_q      <= ch_out_d;
      glob_shadow_q <= glob_shadow_d;
      glob_active_q <= glob_active_d;
      glob_out_q    <= glob_out_d;
      state_q       <= state_d;
      rd_data_q     <= rd_data_d;
      dirty_q       <= dirty_d;
      err_cnt_q     <= err_cnt_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign o_rd_vld       = (state_q == ST_RESP);
  assign o_rd_data      = rd_data_q;
  assign o_dirty        = dirty_q;
  assign o_err_cnt      = err_cnt_q;
  assign o_commit_done  = commit_done_q;
  assign o_in_sync_div  = glob_out_q.sync_div;
  assign o_sync_enabled = glob_out_q.sync_en;
  assign o_int_ext_sync = glob_out_q.int_ext;
  assign o_wheel_add    = glob_out_q.wheel_add;
  assign o_frame_dec    = glob_out_q.frame_dec;

  for (genvar s = 0; s < N_SLOT; s++) begin : g_ts
    assign o_ts_time[s*TS_W +: TS_W] = ts_out_q[s];
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign o_pulse_mask[c*MASK_W +: MASK_W] = {ch_out_q[c].mask[0], ch_out_q[c].mask[1],
                                               ch_out_q[c].mask[2], ch_out_q[c].mask[3]};
    assign o_pulse_hit[c*8 +: 8]    = ch_out_q[c].hit;
    assign o_pulse_gnd[c*8 +: 8]    = ch_out_q[c].gnd;
    assign o_pulse_count[c*4 +: 4]  = ch_out_q[c].count;
    assign o_pulse_hush[c*16 +: 16] = ch_out_q[c].hush;
    assign o_adc_vchn[c*2 +: 2]     = ch_out_q[c].vchn;
    assign o_adc_tick[c*8 +: 8]     = ch_out_q[c].tick;
    assign o_adc_ratio[c*8 +: 8]    = ch_out_q[c].ratio;
    assign o_dac_level[c*8 +: 8]    = ch_out_q[c].dac;
    assign o_adc_delay[c*8 +: 8]    = ch_out_q[c].delay;
  end

endmodule

// File: doc/ctrl_param_bank.md
# ctrl_param_bank

Parametrised, double-buffered per-channel/per-slot parameter store for the pulser/ADC front end; successor to the fixed 4×4 parameter block. Host commands write a shadow bank, which is copied atomically into the active bank on a frame-boundary commit pulse. The block adds register readback through a valid/ready response channel and a saturating error counter. The active bank drives the slot-indexed parameter buses consumed by the slot sequencer.

## Interface
- N_CH, 4, channel count (1..16)
- N_SLOT, 4, time slots per frame (1..16); index = ch*N_SLOT+slot
- MAGIC, 32'hF0AA550F, required command magic
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_cmd_magic  in  32  must equal MAGIC
- i_cmd_command  in  32  command word
- i_cmd_vld / o_cmd_rdy  in/out  1  command handshake
- o_rd_data  out  16  readback value; o_rd_vld out 1; i_rd_rdy in 1
- i_commit  in  1  frame-boundary pulse from sequencer
- o_commit_done  out  1  one-cycle pulse after a copy
- o_dirty  out  1  shadow differs from active (write since last commit)
- o_err_cnt  out  8  saturating count of rejected commands
- i_slot  in  4  current slot (low log2(N_SLOT) bits used)
- o_ts_time  out  16·N_SLOT  slot periods
- o_pulse_mask 4·N_CH (bit-reversed), o_pulse_hit 8·N_CH, o_pulse_gnd 8·N_CH, o_pulse_count 4·N_CH, o_pulse_hush 16·N_CH, o_adc_vchn 2·N_CH, o_adc_tick 8·N_CH, o_adc_ratio 8·N_CH, o_dac_level 8·N_CH, o_adc_delay 8·N_CH  out  per-channel field at i_slot, channel c in bits [c*W +: W]
- o_in_sync_div 16, o_sync_enabled 1, o_int_ext_sync 1, o_wheel_add 8, o_frame_dec 8  out  global fields (active)

## Operation
- Command word fields:
  - [31] reserved, must be 0.
  - [30] read.
  - [29:26] ncmd: 1 mask, 2 rx index, 3 hit, 4 gnd, 5 hush, 6 count, 7 dac, 8 ratio, 9 tick, 10 slot time, 11 adc delay, 12 global sync, 13 global frame.
  - [25:22] ch, [21:18] slot, [15:0] data (LSB-aligned, truncated to field width).
- ncmd 12 data: [15] sync_enabled, [14] int_ext_sync, [12:0] in_sync_div, zero-extended to 16 bits. ncmd 13 data: [15:8] wheel_add, [7:0] frame_dec. ch and slot are ignored for ncmd 10/12/13; ncmd 10 uses slot only.
- Accepted when i_cmd_vld && o_cmd_rdy. Reject (no write, no response, err_cnt+1 saturating at 255) when any of: magic≠MAGIC, [31]=1, ncmd∉1..13, ch≥N_CH, or slot≥N_SLOT (ch/slot checks applied only where used).
- A write updates the shadow entry and sets dirty.
- A read returns the shadow entry zero-extended on o_rd_data. The global commands read back in the same packing used to write them.
- FSM IDLE: o_cmd_rdy=1. An accepted read goes to RESP with o_rd_vld=1 and o_rd_data held. In RESP, o_cmd_rdy=0; on i_rd_rdy, return to IDLE.
- Commit: on i_commit with dirty=1, all active entries ← shadow entries in one cycle, dirty clears, o_commit_done pulses the next cycle. With dirty=0, i_commit does nothing.
- Write and commit in the same cycle: active receives the pre-write shadow; the write lands in shadow; dirty stays 1.
- Reset values, applied to both banks:
  - ts_time 3600.
  - mask 1<<(ch mod 4).
  - hit 20, except entry N_CH*N_SLOT−1 which is 10.
  - gnd 20, except entry N_CH*N_SLOT−1 which is 30.
  - count 4, except entry N_CH*N_SLOT−1 which is 1.
  - hush 1000, vchn ch mod 4, tick 64, ratio 12, dac 120, delay 0.
  - sync_div 100, sync_en 1, int_ext 1, wheel_add 9, frame_dec 234.
  - Control: dirty 0, err_cnt 0, FSM IDLE, o_rd_vld 0, o_rd_data 0, o_commit_done 0.

## Timing
- Parameter outputs are registered from the active bank at index (c, i_slot): 1-cycle latency from an i_slot change.
- Global outputs are registered from active and reflect a commit 1 cycle after the i_commit edge.
- After reset, parameter outputs show slot-0 defaults.
- Read response: o_rd_vld rises the cycle after acceptance. Back-to-back reads are possible, one per 2 cycles minimum with i_rd_rdy held high.
- Asynchronous reset mid-response drops the response; mid-commit restores defaults in both banks.

## Structure
- Package ctrl_param_pkg holds: ncmd localparams, MAGIC, field widths, command-field bit positions, reset-default constants, and a function computing reset defaults per index.
- Sub-module ctrl_param_dec: combinational command decode and validation, producing wr_en, rd_en, field select, index and err.
- Top level holds the shadow/active arrays, the FSM, commit logic and the output mux registers.

## Test plan
- Reset with i_slot=0 → o_pulse_hit ch0 = 20, o_dac_level = 120 on all channels, o_ts_time = 3600 ×4, o_err_cnt = 0.
- Write hit ch2/slot1 = 0x33 → o_dirty=1 and o_pulse_hit unchanged at i_slot=1. Then i_commit → o_commit_done pulse, and ch2 field = 0x33 one cycle later.
- Read of that entry before commit → o_rd_vld=1, o_rd_data=0x0033, o_cmd_rdy=0. Holding i_rd_rdy=0 for 5 cycles keeps the data stable; i_rd_rdy=1 returns the FSM to IDLE.
- Bad magic, ch=N_CH, and ncmd=15 (three commands) → o_err_cnt=3 and no state change. 260 bad commands → o_err_cnt=255.
- Write and i_commit in the same cycle → active keeps the old value, o_dirty=1; the next i_commit applies the new value.
- ncmd 12 with data 0x4064 → after commit, sync_en=0, int_ext=1, sync_div=100.
